// File: rtl/ascon_bdi_packer_pkg.sv
// Shared configuration for the Ascon bdi byte packer.
//   CCW    : default core data-path width in bits (32 or 64)
//   NB     : bytes per CCW word
//   data_e : data-type tag carried alongside every byte and word
package ascon_bdi_packer_pkg;

  localparam int unsigned CCW = 32;
  localparam int unsigned NB  = CCW / 8;

  typedef enum logic [2:0] {
    D_INVALID = 3'd0,
    D_NONCE   = 3'd1,
    D_AD      = 3'd2,
    D_MSG     = 3'd3,
    D_TAG     = 3'd4
  } data_e;

endpackage

// File: rtl/ascon_bdi_packer_outreg.sv
// Output holding register presenting packed words to the core.
// A word is loaded only when the register is free (empty, or being
// handshaken on this edge); it is held stable until bdi_ready.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture load_* as the next presented word
//   load_data/mask  : word bytes (unused bytes zero) and byte mask
//   load_type/eot/eoi : word attributes
//   bdi_ready       : core accepts the presented word
//   bdi*            : registered word outputs
//   occupied        : a word is currently presented
module ascon_bdi_outreg
  import ascon_bdi_packer_pkg::*;
#(
  parameter int unsigned CCW = ascon_bdi_packer_pkg::CCW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CCW-1:0]   load_data,
  input  logic [CCW/8-1:0] load_mask,
  input  data_e            load_type,
  input  logic             load_eot,
  input  logic             load_eoi,
  input  logic             bdi_ready,
  output logic [CCW-1:0]   bdi,
  output logic [CCW/8-1:0] bdi_valid,
  output data_e            bdi_type,
  output logic             bdi_eot,
  output logic             bdi_eoi,
  output logic             occupied
);

  assign occupied = |bdi_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      bdi       <= '0;
      bdi_valid <= '0;
      bdi_type  <= D_INVALID;
      bdi_eot   <= 1'b0;
      bdi_eoi   <= 1'b0;
    end else if (load) begin
      bdi       <= load_data;
      bdi_valid <= load_mask;
      bdi_type  <= load_type;
      bdi_eot   <= load_eot;
      bdi_eoi   <= load_eoi;
    end else if (occupied && bdi_ready) begin
      bdi_valid <= '0;
      bdi_type  <= D_INVALID;
      bdi_eot   <= 1'b0;
      bdi_eoi   <= 1'b0;
    end
  end

endmodule

// File: rtl/ascon_bdi_packer.sv
// Byte-to-word packer feeding the ascon_core bdi port.
// Bytes tagged with type / last / eoi are packed low-byte-first into
// CCW-bit words with a contiguous low-aligned byte mask.
// Build option: ASCON_BDI_PACK_SKID_EN -- the accumulator keeps filling
// while the output register waits (1 byte/cycle); otherwise FILL/HOLD
// single-buffer operation (NB bytes per NB+1 cycles).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   in_data/in_valid/in_ready       : byte stream handshake
//   in_type/in_last/in_eoi          : byte type, end of segment, end of input
//   bdi/bdi_valid/bdi_ready         : packed word, byte mask, core ready
//   bdi_type/bdi_eot/bdi_eoi        : word attributes
module ascon_bdi_packer
  import ascon_bdi_packer_pkg::*;
#(
  parameter int unsigned CCW = ascon_bdi_packer_pkg::CCW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  data_e            in_type,
  input  logic             in_last,
  input  logic             in_eoi,
  output logic [CCW-1:0]   bdi,
  output logic [CCW/8-1:0] bdi_valid,
  input  logic             bdi_ready,
  output data_e            bdi_type,
  output logic             bdi_eot,
  output logic             bdi_eoi
);

  localparam int unsigned NBW = CCW / 8;
  localparam int unsigned CW  = $clog2(NBW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NBW);

  typedef enum logic {S_FILL, S_HOLD} state_e;

  state_e              state;
  logic [NBW-1:0][7:0] acc, w_acc;
  logic [CW-1:0]       cnt, w_cnt, base_cnt, mask_cnt;
  data_e               acc_type, w_type;
  logic                out_occ, out_free;
  logic                mismatch, accept, close_new, close_eot, close_eoi;
  logic                load, load_eot, load_eoi;
  logic [CCW-1:0]      load_data;
  logic [NBW-1:0]      load_mask;
  data_e               load_type;
`ifdef ASCON_BDI_PACK_SKID_EN
  logic                pend_eot, pend_eoi;
`endif

  assign out_free = !out_occ || bdi_ready;

  always_comb begin
    mismatch = (state == S_FILL) && (cnt != '0) && (in_type != acc_type);
`ifdef ASCON_BDI_PACK_SKID_EN
    in_ready = !rst && !mismatch && ((state == S_FILL) || out_free);
`else
    in_ready = !rst && !mismatch && (state == S_FILL);
`endif
    accept = in_valid && in_ready;

    // In HOLD the accumulator content is the parked word; a byte accepted
    // there starts a fresh word.
    base_cnt = (state == S_HOLD) ? '0 : cnt;
    w_acc    = (state == S_HOLD) ? '0 : acc;
    w_type   = (base_cnt == '0) ? in_type : acc_type;
    w_cnt    = base_cnt;
    if (accept) begin
      for (int unsigned i = 0; i < NBW; i++)
        if (CW'(i) == base_cnt) w_acc[i] = in_data;
      w_cnt = base_cnt + CW'(1);
    end

    close_new = (accept && ((w_cnt == CNT_FULL) || in_last)) || (in_valid && mismatch);
    close_eot = mismatch || (accept && in_last);
    close_eoi = accept && in_last && in_eoi;

    load      = 1'b0;
    load_data = w_acc;
    load_type = w_type;
    load_eot  = close_eot;
    load_eoi  = close_eoi;
    mask_cnt  = w_cnt;
`ifdef ASCON_BDI_PACK_SKID_EN
    if ((state == S_HOLD) && out_free) begin
      load      = 1'b1;
      load_data = acc;
      load_type = acc_type;
      load_eot  = pend_eot;
      load_eoi  = pend_eoi;
      mask_cnt  = cnt;
    end else begin
      load = (state == S_FILL) && close_new && out_free;
    end
`else
    load = (state == S_FILL) && close_new;
`endif
    for (int unsigned i = 0; i < NBW; i++)
      load_mask[i] = CW'(i) < mask_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      cnt      <= '0;
      acc      <= '0;
      acc_type <= D_INVALID;
`ifdef ASCON_BDI_PACK_SKID_EN
      pend_eot <= 1'b0;
      pend_eoi <= 1'b0;
`endif
    end else begin
`ifdef ASCON_BDI_PACK_SKID_EN
      // HOLD = closed word parked in the accumulator waiting for the
      // output register; it leaves on the edge the register frees up.
      if ((state == S_HOLD) && !out_free) begin
        state <= S_HOLD;
      end else if (close_new && !((state == S_FILL) && out_free)) begin
        state    <= S_HOLD;
        acc      <= w_acc;
        cnt      <= w_cnt;
        acc_type <= w_type;
        pend_eot <= close_eot;
        pend_eoi <= close_eoi;
      end else if (close_new) begin
        state <= S_FILL;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        state <= S_FILL;
        acc   <= w_acc;
        cnt   <= w_cnt;
        if (accept) acc_type <= w_type;
      end
`else
      // The word is copied to the output register on close, so the
      // accumulator is cleared then rather than at the handshake.
      case (state)
        S_FILL: begin
          if (close_new) begin
            state <= S_HOLD;
            acc   <= '0;
            cnt   <= '0;
          end else if (accept) begin
            acc      <= w_acc;
            cnt      <= w_cnt;
            acc_type <= w_type;
          end
        end
        S_HOLD: begin
          if (out_free) state <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
`endif
    end
  end

  ascon_bdi_outreg #(.CCW(CCW)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_mask (load_mask),
    .load_type (load_type),
    .load_eot  (load_eot),
    .load_eoi  (load_eoi),
    .bdi_ready (bdi_ready),
    .bdi       (bdi),
    .bdi_valid (bdi_valid),
    .bdi_type  (bdi_type),
    .bdi_eot   (bdi_eot),
    .bdi_eoi   (bdi_eoi),
    .occupied  (out_occ)
  );

endmodule

// File: tb/tb_ascon_bdi_packer.sv
module tb_ascon_bdi_packer;
  import ascon_bdi_packer_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  mask;
    data_e       typ;
    logic        eot;
    logic        eoi;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  in_data;
  logic        in_valid, in_ready, in_last, in_eoi;
  data_e       in_type;
  logic [31:0] bdi;
  logic [3:0]  bdi_valid;
  logic        bdi_ready, bdi_eot, bdi_eoi;
  data_e       bdi_type;

  int errors = 0;
  int checks = 0;
  word_t exp_q[$];

  ascon_bdi_packer #(.CCW(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_last(in_last), .in_eoi(in_eoi),
    .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
    .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cmp_word(input string tag, input logic [63:0] d, input logic [7:0] m,
                          input data_e t, input logic eot, input logic eoi, input word_t e);
    check({tag, "_data"}, d, e.data);
    check({tag, "_mask"}, 64'(m), 64'(e.mask));
    check({tag, "_type"}, 64'(t), 64'(e.typ));
    check({tag, "_eot"}, 64'(eot), 64'(e.eot));
    check({tag, "_eoi"}, 64'(eoi), 64'(e.eoi));
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] m, input data_e t,
                      input logic eot, input logic eoi);
    word_t w;
    w.data = d; w.mask = m; w.typ = t; w.eot = eot; w.eoi = eoi;
    exp_q.push_back(w);
  endtask

  // Monitor: pops an expectation for every word the core accepts.
  always @(negedge clk) begin : mon32
    word_t e;
    if (!rst && (|bdi_valid) && bdi_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %0h expected no word", bdi);
      end else begin
        e = exp_q.pop_front();
        cmp_word("word", 64'(bdi), 8'(bdi_valid), bdi_type, bdi_eot, bdi_eoi, e);
      end
    end
  end

  task automatic send(input logic [7:0] d, input data_e t, input logic last, input logic eoi);
    int n = 0;
    in_data = d; in_type = t; in_last = last; in_eoi = eoi; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_eoi = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    check("drain_pending_words", 64'(exp_q.size()), 64'd0);
  endtask

`ifdef ASCON_BDI_PACK_SKID_EN
  logic [7:0]  in_data2;
  logic        in_valid2, in_ready2, in_last2, in_eoi2;
  data_e       in_type2;
  logic [63:0] bdi2;
  logic [7:0]  bdi_valid2;
  logic        bdi_ready2, bdi_eot2, bdi_eoi2;
  data_e       bdi_type2;
  word_t       exp_q2[$];

  ascon_bdi_packer #(.CCW(64)) dut64 (
    .clk(clk), .rst(rst),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_type(in_type2), .in_last(in_last2), .in_eoi(in_eoi2),
    .bdi(bdi2), .bdi_valid(bdi_valid2), .bdi_ready(bdi_ready2),
    .bdi_type(bdi_type2), .bdi_eot(bdi_eot2), .bdi_eoi(bdi_eoi2)
  );

  always @(negedge clk) begin : mon64
    word_t e;
    if (!rst && (|bdi_valid2) && bdi_ready2) begin
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word64: got %0h expected no word", bdi2);
      end else begin
        e = exp_q2.pop_front();
        cmp_word("word64", bdi2, bdi_valid2, bdi_type2, bdi_eot2, bdi_eoi2, e);
      end
    end
  end
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_type = D_AD;
    in_last = 1'b0; in_eoi = 1'b0; bdi_ready = 1'b1;
`ifdef ASCON_BDI_PACK_SKID_EN
    in_valid2 = 1'b0; in_data2 = '0; in_type2 = D_MSG;
    in_last2 = 1'b0; in_eoi2 = 1'b0; bdi_ready2 = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_bdi_valid", 64'(bdi_valid), 64'd0);
    check("rst_bdi", 64'(bdi), 64'd0);
    check("rst_bdi_type", 64'(bdi_type), 64'(D_INVALID));
    check("rst_bdi_eot", 64'(bdi_eot), 64'd0);
    check("rst_bdi_eoi", 64'(bdi_eoi), 64'd0);
    @(posedge clk); #1;

    // AD 01..05: full word then partial last word
    push(64'h04030201, 8'hF, D_AD, 1'b0, 1'b0);
    push(64'h00000005, 8'h1, D_AD, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) send(8'(i), D_AD, i == 5, 1'b0);
    drain();

    // MSG AA BB CC DD ends segment and input
    push(64'hDDCCBBAA, 8'hF, D_MSG, 1'b1, 1'b1);
    send(8'hAA, D_MSG, 1'b0, 1'b0);
    send(8'hBB, D_MSG, 1'b0, 1'b0);
    send(8'hCC, D_MSG, 1'b0, 1'b0);
    send(8'hDD, D_MSG, 1'b1, 1'b1);
    drain();

    // Type change without in_last closes the partial AD word
    push(64'h00000201, 8'h3, D_AD, 1'b1, 1'b0);
    push(64'h00000003, 8'h1, D_MSG, 1'b1, 1'b0);
    send(8'h01, D_AD, 1'b0, 1'b0);
    send(8'h02, D_AD, 1'b0, 1'b0);
    in_data = 8'h03; in_type = D_MSG; in_last = 1'b1; in_eoi = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("mismatch_in_ready", 64'(in_ready), 64'd0);
    send(8'h03, D_MSG, 1'b1, 1'b0);
    drain();

    // Reset after two bytes discards them
    send(8'h10, D_TAG, 1'b0, 1'b0);
    send(8'h20, D_TAG, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_bdi_valid", 64'(bdi_valid), 64'd0);
    @(posedge clk); #1;
    push(64'h40302010, 8'hF, D_TAG, 1'b1, 1'b0);
    send(8'h10, D_TAG, 1'b0, 1'b0);
    send(8'h20, D_TAG, 1'b0, 1'b0);
    send(8'h30, D_TAG, 1'b0, 1'b0);
    send(8'h40, D_TAG, 1'b1, 1'b0);
    drain();

    // Core stalls with a word presented
    bdi_ready = 1'b0;
    push(64'h44332211, 8'hF, D_NONCE, 1'b0, 1'b0);
    send(8'h11, D_NONCE, 1'b0, 1'b0);
    send(8'h22, D_NONCE, 1'b0, 1'b0);
    send(8'h33, D_NONCE, 1'b0, 1'b0);
    send(8'h44, D_NONCE, 1'b0, 1'b0);
    snap = 32'h44332211;
`ifdef ASCON_BDI_PACK_SKID_EN
    push(64'h88776655, 8'hF, D_NONCE, 1'b0, 1'b0);
    push(64'h00000099, 8'h1, D_NONCE, 1'b1, 1'b0);
    for (int i = 5; i <= 8; i++) begin
      send(8'(i * 16 + i), D_NONCE, 1'b0, 1'b0);
      check("stall_bdi", 64'(bdi), 64'(snap));
      check("stall_valid", 64'(bdi_valid), 64'hF);
    end
    in_data = 8'h99; in_type = D_NONCE; in_last = 1'b1; in_eoi = 1'b0; in_valid = 1'b1;
`else
    push(64'h00000055, 8'h1, D_NONCE, 1'b1, 1'b0);
    in_data = 8'h55; in_type = D_NONCE; in_last = 1'b1; in_eoi = 1'b0; in_valid = 1'b1;
`endif
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_bdi", 64'(bdi), 64'(snap));
      check("stall_valid", 64'(bdi_valid), 64'hF);
      check("stall_type", 64'(bdi_type), 64'(D_NONCE));
      check("stall_eot", 64'(bdi_eot), 64'd0);
    end
    @(posedge clk); #1 bdi_ready = 1'b1;
`ifdef ASCON_BDI_PACK_SKID_EN
    send(8'h99, D_NONCE, 1'b1, 1'b0);
`else
    send(8'h55, D_NONCE, 1'b1, 1'b0);
`endif
    drain();

`ifdef ASCON_BDI_PACK_SKID_EN
    // Wide build sustains one byte per cycle
    begin
      word_t w;
      w.data = 64'h0706050403020100; w.mask = 8'hFF; w.typ = D_MSG; w.eot = 1'b0; w.eoi = 1'b0;
      exp_q2.push_back(w);
      w.data = 64'h0F0E0D0C0B0A0908; w.eot = 1'b1; w.eoi = 1'b1;
      exp_q2.push_back(w);
    end
    for (int i = 0; i < 16; i++) begin
      in_data2 = 8'(i); in_type2 = D_MSG; in_last2 = (i == 15); in_eoi2 = (i == 15);
      in_valid2 = 1'b1;
      @(negedge clk);
      check("skid64_in_ready", 64'(in_ready2), 64'd1);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0; in_last2 = 1'b0; in_eoi2 = 1'b0;
    repeat (10) @(negedge clk);
    check("skid64_pending_words", 64'(exp_q2.size()), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
